datapath_ctrl: RTL and testbench

- Instruction-sequencing controller that drives the control inputs of the existing `datapath` block (register file, A/B/C registers, shifter, ALU, status).
- Latches a 16-bit instruction, decodes it, and steps a Moore FSM through the register-read, ALU and write-back cycles that `datapath` requires.
- Sits between the instruction source and `datapath`. All control outputs connect 1:1 to the same-named `datapath` ports.

---
 rtl/datapath_ctrl_pkg.sv | 49 ++++
 rtl/datapath_ctrl_instr_dec.sv | 53 +++++
 rtl/datapath_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_datapath_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg
//   Shared encodings for the datapath instruction sequencer: opcode and op
//   field values, ALU operation codes, the FSM state type and the decoded
//   instruction class used by instr_dec and datapath_ctrl.
package datapath_ctrl_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field, meaning depends on opcode
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_ALU       = 3'd5,
    ST_WRITE_REG = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_MOV_IMM = 3'd0,
    CLS_MOV_REG = 3'd1,
    CLS_ADD     = 3'd2,
    CLS_CMP     = 3'd3,
    CLS_AND     = 3'd4,
    CLS_MVN     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_cls_e;

  function automatic logic [15:0] sext8(input logic [7:0] imm);
    return {{8{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// instr_dec
//   Purely combinational field extraction and legality decode of a 16-bit
//   instruction word.
//   Ports:
//     ir_i         instruction word
//     opcode_o     ir[15:13]
//     op_o         ir[12:11]
//     rn_o/rd_o/rm_o register indices ir[10:8] / ir[7:5] / ir[2:0]
//     sh_o         shifter control ir[4:3]
//     sximm8_o     sign-extended ir[7:0]
//     cls_o        instruction class
//     is_illegal_o 1 when the word is not a supported instruction
module instr_dec
  import datapath_ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rm_o,
  output logic [1:0]  sh_o,
  output logic [15:0] sximm8_o,
  output instr_cls_e  cls_o,
  output logic        is_illegal_o
);

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm8_o = sext8(ir_i[7:0]);

  always_comb begin
    cls_o = CLS_ILLEGAL;
    if (opcode_o == OPC_MOV) begin
      if (op_o == OP_MOV_IMM)      cls_o = CLS_MOV_IMM;
      else if (op_o == OP_MOV_REG) cls_o = CLS_MOV_REG;
    end else if (opcode_o == OPC_ALU) begin
      unique case (op_o)
        OP_ADD:  cls_o = CLS_ADD;
        OP_CMP:  cls_o = CLS_CMP;
        OP_AND:  cls_o = CLS_AND;
        default: cls_o = CLS_MVN;
      endcase
    end
  end

  assign is_illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl
//   Instruction sequencer for the datapath block. Latches an instruction in
//   WAIT, decodes it and walks the register-read / ALU / write-back cycles.
//   All outputs are registered Moore outputs of the state being entered.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   WAIT      | idle, w=1, accepts load / s
//   DECODE    | classify instruction, pulse illegal if unsupported
//   WRITE_IMM | write sximm8 into Rn
//   GET_A     | read Rn into A
//   GET_B     | read Rm into B
//   ALU       | run shifter+ALU, load C (or status for CMP)
//   WRITE_REG | write C into Rd
//
//   Ports: clk, reset (sync, active-high), load, in[15:0], s  -> inputs
//          w, illegal, readnum, writenum, write, vsel, loada, loadb, loadc,
//          loads, asel, bsel, shift, ALUop, datapath_in      -> outputs
//   Optional: DATAPATH_CTRL_RETIRE_CNT_EN adds retired[15:0], a wrapping
//   count of completed (non-illegal) instructions.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] in,
  input  logic          s,
  output logic          w,
  output logic          illegal,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
`ifdef DATAPATH_CTRL_RETIRE_CNT_EN
  output logic [15:0]   retired,
`endif
  output logic [DW-1:0] datapath_in
);

  state_e        state_q, state_d;
  logic [15:0]   ir_q, ir_d;

  logic [2:0]    opcode, rn, rd, rm;
  logic [1:0]    op, sh;
  logic [15:0]   sximm8;
  instr_cls_e    cls;
  logic          is_illegal;

  logic          w_d, illegal_d, write_d, vsel_d;
  logic          loada_d, loadb_d, loadc_d, loads_d, asel_d;
  logic [2:0]    readnum_d, writenum_d;
  logic [1:0]    shift_d, aluop_d;

  // Decoding ir_d rather than ir_q lets the registered outputs see a word
  // loaded in the same cycle as s; outside WAIT the two are identical.
  instr_dec u_dec (
    .ir_i        (ir_d),
    .opcode_o    (opcode),
    .op_o        (op),
    .rn_o        (rn),
    .rd_o        (rd),
    .rm_o        (rm),
    .sh_o        (sh),
    .sximm8_o    (sximm8),
    .cls_o       (cls),
    .is_illegal_o(is_illegal)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_WAIT: begin
        if (load) ir_d = in;
        if (s)    state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_illegal) begin
          state_d = ST_WAIT;
        end else begin
          unique case (cls)
            CLS_MOV_IMM:          state_d = ST_WRITE_IMM;
            CLS_MOV_REG, CLS_MVN: state_d = ST_GET_B;
            default:              state_d = ST_GET_A;
          endcase
        end
      end
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_ALU;
      ST_ALU:       state_d = (cls == CLS_CMP) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_WRITE_REG: state_d = ST_WAIT;
      default:      state_d = ST_WAIT;
    endcase
  end

  // Output values for the state about to be entered.
  always_comb begin
    w_d        = 1'b0;
    illegal_d  = 1'b0;
    write_d    = 1'b0;
    vsel_d     = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    readnum_d  = 3'd0;
    writenum_d = 3'd0;
    shift_d    = 2'b00;
    aluop_d    = ALU_ADD;
    unique case (state_d)
      ST_WAIT:   w_d = 1'b1;
      ST_DECODE: illegal_d = is_illegal;
      ST_GET_A: begin
        readnum_d = rn;
        loada_d   = 1'b1;
      end
      ST_GET_B: begin
        readnum_d = rm;
        loadb_d   = 1'b1;
      end
      ST_ALU: begin
        shift_d = sh;
        aluop_d = (opcode == OPC_ALU) ? op : ALU_ADD;
        asel_d  = (cls == CLS_MOV_REG);
        loads_d = (cls == CLS_CMP);
        loadc_d = (cls != CLS_CMP);
      end
      ST_WRITE_IMM: begin
        writenum_d = rn;
        vsel_d     = 1'b1;
        write_d    = 1'b1;
      end
      ST_WRITE_REG: begin
        writenum_d = rd;
        write_d    = 1'b1;
      end
      default: w_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      ir_q        <= '0;
      w           <= 1'b1;
      illegal     <= 1'b0;
      write       <= 1'b0;
      vsel        <= 1'b0;
      loada       <= 1'b0;
      loadb       <= 1'b0;
      loadc       <= 1'b0;
      loads       <= 1'b0;
      asel        <= 1'b0;
      bsel        <= 1'b0;
      readnum     <= 3'd0;
      writenum    <= 3'd0;
      shift       <= 2'b00;
      ALUop       <= ALU_ADD;
      datapath_in <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      w           <= w_d;
      illegal     <= illegal_d;
      write       <= write_d;
      vsel        <= vsel_d;
      loada       <= loada_d;
      loadb       <= loadb_d;
      loadc       <= loadc_d;
      loads       <= loads_d;
      asel        <= asel_d;
      bsel        <= 1'b0;
      readnum     <= readnum_d;
      writenum    <= writenum_d;
      shift       <= shift_d;
      ALUop       <= aluop_d;
      datapath_in <= sximm8;
    end
  end

`ifdef DATAPATH_CTRL_RETIRE_CNT_EN
  logic [15:0] retired_q;
  logic        retire_evt;

  // A completed instruction is the final step of any legal sequence.
  assign retire_evt = (state_q == ST_WRITE_IMM) || (state_q == ST_WRITE_REG) ||
                      ((state_q == ST_ALU) && (cls == CLS_CMP));

  always_ff @(posedge clk) begin
    if (reset)           retired_q <= 16'd0;
    else if (retire_evt) retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset, load, s;
  logic [15:0] instr;
  logic        w, illegal, write, vsel, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datapath_ctrl #(.DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .in         (instr),
    .s          (s),
    .w          (w),
    .illegal    (illegal),
    .readnum    (readnum),
    .writenum   (writenum),
    .write      (write),
    .vsel       (vsel),
    .loada      (loada),
    .loadb      (loadb),
    .loadc      (loadc),
    .loads      (loads),
    .asel       (asel),
    .bsel       (bsel),
    .shift      (shift),
    .ALUop      (ALUop),
    .datapath_in(datapath_in)
  );

  // Behavioural model of the attached datapath block.
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc, ain, bsh, alu_out;
  logic        zflag, dp_clr;

  always_comb begin
    ain = asel ? 16'h0000 : ra;
    case (shift)
      2'b01:   bsh = {rb[14:0], 1'b0};
      2'b10:   bsh = {1'b0, rb[15:1]};
      2'b11:   bsh = {rb[15], rb[15:1]};
      default: bsh = rb;
    endcase
    case (ALUop)
      2'b00:   alu_out = ain + bsh;
      2'b01:   alu_out = ain - bsh;
      2'b10:   alu_out = ain & bsh;
      default: alu_out = ~bsh;
    endcase
  end

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      ra <= 16'h0; rb <= 16'h0; rc <= 16'h0; zflag <= 1'b0;
    end else begin
      if (write) rf[writenum] <= vsel ? datapath_in : rc;
      if (loada) ra <= rf[readnum];
      if (loadb) rb <= rf[readnum];
      if (loadc) rc <= alu_out;
      if (loads) zflag <= (alu_out == 16'h0000);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction with load and s together, then count busy cycles
  // and the enables seen until w returns (bounded).
  task automatic run_instr(input logic [15:0] word, output int busy, output int writes,
                           output int illegals, output int loads_n);
    busy = 0; writes = 0; illegals = 0; loads_n = 0;
    instr = word; load = 1'b1; s = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b0;
    for (int k = 0; k < 20 && w == 1'b0; k++) begin
      busy++;
      writes   += int'(write);
      illegals += int'(illegal);
      loads_n  += int'(loads);
      @(negedge clk);
    end
    if (w !== 1'b1) busy = 99;
  endtask

  int busy, writes, illegals, loads_n;

  initial begin
    reset = 1'b1; load = 1'b0; s = 1'b0; instr = 16'h0000; dp_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_w", 16'(w), 16'h1);
    chk("rst_write", 16'(write), 16'h0);
    chk("rst_loads_all", 16'({loada, loadb, loadc, loads}), 16'h0);
    chk("rst_illegal", 16'(illegal), 16'h0);
    chk("rst_dp_in", datapath_in, 16'h0000);
    reset = 1'b0; dp_clr = 1'b0;

    // MOV R0,#7 with load and s in the same cycle
    instr = 16'hD007; load = 1'b1; s = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b0;
    chk("mi_decode_w", 16'(w), 16'h0);
    @(negedge clk);
    chk("mi_write", 16'(write), 16'h1);
    chk("mi_vsel", 16'(vsel), 16'h1);
    chk("mi_writenum", 16'(writenum), 16'h0);
    chk("mi_dp_in", datapath_in, 16'h0007);
    @(negedge clk);
    chk("mi_w_back", 16'(w), 16'h1);
    chk("mi_write_off", 16'(write), 16'h0);
    chk("r0", rf[0], 16'h0007);

    // MOV R1,#-2: load first, then s; a load during DECODE must be ignored
    instr = 16'hD1FE; load = 1'b1;
    @(negedge clk);
    load = 1'b0; instr = 16'hFFFF;
    chk("load_only_w", 16'(w), 16'h1);
    s = 1'b1;
    @(negedge clk);
    s = 1'b0; load = 1'b1; instr = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    chk("mi2_dp_in", datapath_in, 16'hFFFE);
    chk("mi2_writenum", 16'(writenum), 16'h1);
    @(negedge clk);
    chk("mi2_w_back", 16'(w), 16'h1);
    chk("r1", rf[1], 16'hFFFE);

    // ADD R2,R1,R0,LSL#1 step by step
    instr = 16'hA148; load = 1'b1; s = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b0;
    chk("add_decode_w", 16'(w), 16'h0);
    @(negedge clk);
    chk("add_geta_readnum", 16'(readnum), 16'h1);
    chk("add_geta_loada", 16'({loada, loadb}), 16'h2);
    @(negedge clk);
    chk("add_getb_readnum", 16'(readnum), 16'h0);
    chk("add_getb_loadb", 16'({loada, loadb}), 16'h1);
    @(negedge clk);
    chk("add_alu_shift", 16'(shift), 16'h1);
    chk("add_alu_op", 16'(ALUop), 16'h0);
    chk("add_alu_lc_ls_as", 16'({loadc, loads, asel}), 16'h4);
    @(negedge clk);
    chk("add_wr_writenum", 16'(writenum), 16'h2);
    chk("add_wr_write_vsel", 16'({write, vsel}), 16'h2);
    @(negedge clk);
    chk("add_w_back", 16'(w), 16'h1);
    chk("r2_add", rf[2], 16'h000C);

    // CMP R0,R1 (7 - 0xFFFE = 9, not zero)
    run_instr(16'hA801, busy, writes, illegals, loads_n);
    chk("cmp_busy", 16'(busy), 16'd4);
    chk("cmp_writes", 16'(writes), 16'd0);
    chk("cmp_loads", 16'(loads_n), 16'd1);
    chk("cmp_z0", 16'(zflag), 16'h0);
    // CMP R1,R1 sets Z
    run_instr(16'hA901, busy, writes, illegals, loads_n);
    chk("cmp_z1", 16'(zflag), 16'h1);

    // MVN R3,R0 -> ~7
    run_instr(16'hB860, busy, writes, illegals, loads_n);
    chk("mvn_busy", 16'(busy), 16'd4);
    chk("r3_mvn", rf[3], 16'hFFF8);
    // MOV R4,R1,ASR#1 -> 0xFFFF (A holds 0xFFFE, so asel must zero it)
    run_instr(16'hC099, busy, writes, illegals, loads_n);
    chk("movr_busy", 16'(busy), 16'd4);
    chk("r4_movr", rf[4], 16'hFFFF);
    // AND R5,R1,R0 -> 6
    run_instr(16'hB1A0, busy, writes, illegals, loads_n);
    chk("and_busy", 16'(busy), 16'd5);
    chk("r5_and", rf[5], 16'h0006);

    // Illegal words
    run_instr(16'h0000, busy, writes, illegals, loads_n);
    chk("ill0_busy", 16'(busy), 16'd1);
    chk("ill0_pulse", 16'(illegals), 16'd1);
    chk("ill0_writes", 16'(writes), 16'd0);
    run_instr(16'hD800, busy, writes, illegals, loads_n);
    chk("ill1_pulse", 16'(illegals), 16'd1);
    chk("ill1_writes", 16'(writes), 16'd0);

    // MOV R2,#0x55, then ADD into R2 aborted by reset in GET_B
    run_instr(16'hD255, busy, writes, illegals, loads_n);
    chk("r2_pre", rf[2], 16'h0055);
    instr = 16'hA148; load = 1'b1; s = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_getb", 16'(loadb), 16'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_w", 16'(w), 16'h1);
    chk("abort_write", 16'(write), 16'h0);
    chk("abort_loadb", 16'(loadb), 16'h0);
    writes = 0;
    for (int k = 0; k < 4; k++) begin
      writes += int'(write);
      @(negedge clk);
    end
    chk("abort_no_write", 16'(writes), 16'd0);
    chk("r2_unchanged", rf[2], 16'h0055);

    // Normal operation resumes after the abort
    run_instr(16'hA148, busy, writes, illegals, loads_n);
    chk("add2_busy", 16'(busy), 16'd5);
    chk("r2_add2", rf[2], 16'h000C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
